// File: rtl/router_1xn.sv
// router_1xn: 1-to-NUM_PORTS byte-serial packet router.
// Latches each header, steers header/payload/parity into the addressed output
// FIFO, flags parity/length errors, drops packets to nonexistent ports and
// flushes any output FIFO whose reader stalls for TIMEOUT cycles.
module router_1xn #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]        read_enb,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic                        busy,
    output logic                        err,
    output logic                        drop
);
    localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_EMPTY, S_LFD, S_LOAD, S_CHECK, S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [LEN_W-1:0]  pcnt_q, pcnt_d;
    logic              perr_q, perr_d;
    logic              drop_q, drop_d;

    logic [ADDR_W-1:0]    tgt_addr, in_addr;
    logic [LEN_W-1:0]     hdr_len;
    logic [NUM_PORTS-1:0] empty_v, full_v, flush_v, sel_v, wr_v;
    logic                 in_valid, in_empty, tgt_empty, tgt_full, tgt_flush;
    logic                 wr_en, wr_hdr;
    logic [DATA_W-1:0]    wr_data;

    assign tgt_addr = hdr_q[ADDR_W-1:0];
    assign hdr_len  = hdr_q[DATA_W-1:ADDR_W];
    assign in_addr  = data_in[ADDR_W-1:0];
    assign wr_data  = wr_hdr ? hdr_q : data_in;
    assign wr_v     = wr_en ? sel_v : '0;
    assign err      = (state_q == S_CHECK) && perr_q;
    assign drop     = drop_q;

    // Look up FIFO status for the held target port and for an incoming header.
    always_comb begin
        in_valid  = 1'b0;
        in_empty  = 1'b1;
        tgt_empty = 1'b1;
        tgt_full  = 1'b0;
        tgt_flush = 1'b0;
        sel_v     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (in_addr == ADDR_W'(k)) begin
                in_valid = 1'b1;
                in_empty = empty_v[k];
            end
            if (tgt_addr == ADDR_W'(k)) begin
                sel_v[k]  = 1'b1;
                tgt_empty = empty_v[k];
                tgt_full  = full_v[k];
                tgt_flush = flush_v[k];
            end
        end
    end

    // Packet FSM: next state, busy, FIFO write request and parity/length tracking.
    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        parity_d = parity_q;
        pcnt_d   = pcnt_q;
        perr_d   = perr_q;
        drop_d   = 1'b0;
        busy     = 1'b0;
        wr_en    = 1'b0;
        wr_hdr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    hdr_d    = data_in;
                    parity_d = data_in;
                    pcnt_d   = '0;
                    if (!in_valid)     state_d = S_DROP;
                    else if (in_empty) state_d = S_LFD;
                    else               state_d = S_WAIT_EMPTY;
                end
            end
            S_WAIT_EMPTY: begin
                busy = 1'b1;
                if (tgt_flush)      state_d = S_DROP;
                else if (tgt_empty) state_d = S_LFD;
            end
            S_LFD: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_hdr  = 1'b1;
                state_d = tgt_flush ? S_DROP : S_LOAD;
            end
            S_LOAD: begin
                busy = tgt_full;
                if (!tgt_full) begin
                    wr_en = 1'b1;
                    if (pkt_valid) begin
                        parity_d = parity_q ^ data_in;
                        pcnt_d   = (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;
                    end else begin
                        perr_d  = (data_in != parity_q) || (pcnt_q != hdr_len);
                        state_d = S_CHECK;
                    end
                end
                // A flush of the target aborts the packet; if the parity byte
                // arrives on the same edge the packet is already over.
                if (tgt_flush) begin
                    if (!tgt_full && !pkt_valid) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and pulse flags are reset; header/parity/count hold data only.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            perr_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
            drop_q  <= drop_d;
        end
        hdr_q    <= hdr_d;
        parity_q <= parity_d;
        pcnt_q   <= pcnt_d;
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]  wptr_q, rptr_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [TMO_W-1:0]  tmo_q;
        logic [DATA_W-1:0] dout_q;
        logic              do_wr, do_rd, stall;

        assign empty_v[k] = (cnt_q == '0);
        assign full_v[k]  = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign do_wr      = wr_v[k] && !full_v[k];
        assign do_rd      = read_enb[k] && !empty_v[k];
        assign stall      = !empty_v[k] && !read_enb[k];
        assign flush_v[k] = stall && (tmo_q == TMO_W'(TIMEOUT - 1));
        assign vld_out[k] = !empty_v[k];
        assign data_out[k*DATA_W +: DATA_W] = dout_q;

        // Storage array: written at the write pointer, never reset.
        always_ff @(posedge clock) begin
            if (do_wr) mem_q[wptr_q] <= wr_data;
        end

        // Pointers, occupancy, stall timer and output register; a flush wins over a write.
        always_ff @(posedge clock) begin
            if (!resetn) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                tmo_q  <= '0;
                dout_q <= '0;
            end else begin
                if (do_rd) dout_q <= mem_q[rptr_q];
                if (flush_v[k]) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                    tmo_q  <= '0;
                end else begin
                    if (do_wr) wptr_q <= wptr_q + 1'b1;
                    if (do_rd) rptr_q <= rptr_q + 1'b1;
                    if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
                    else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
                    tmo_q <= stall ? tmo_q + 1'b1 : '0;
                end
            end
        end
    end

endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised 1-to-N packet router: the next generation of the 1x3 router top level, with configurable data width, output port count, FIFO depth and soft-reset timeout. It accepts one byte-serial packet stream, latches the header, and steers the packet into one of `NUM_PORTS` output FIFOs. It checks parity and payload length, drops packets to nonexistent ports, and flushes any port whose reader stalls. It sits between the upstream packet source and the N downstream readers.

## Interface
- `DATA_W`, 8: byte width. Must be greater than `ADDR_W`.
- `NUM_PORTS`, 3: output ports, 2..16. `ADDR_W = max(1, clog2(NUM_PORTS))`.
- `FIFO_DEPTH`, 16: entries per output FIFO. Power of 2, at least 4.
- `TIMEOUT`, 30: stalled-read cycles before a port soft-resets. At least 2.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `pkt_valid`  in  1  high for header and payload bytes; low on the parity byte.
- `data_in`  in  DATA_W  packet byte.
- `read_enb`  in  NUM_PORTS  per-port read request.
- `data_out`  out  NUM_PORTS*DATA_W  port k occupies `[k*DATA_W +: DATA_W]`.
- `vld_out`  out  NUM_PORTS  port k FIFO non-empty.
- `busy`  out  1  byte on `data_in` is not consumed this cycle; upstream holds `data_in` and `pkt_valid`.
- `err`  out  1  one-cycle pulse on parity or length mismatch.
- `drop`  out  1  one-cycle pulse when a packet is discarded.

## Operation
- **Packet format.**
  - Header: `addr = data_in[ADDR_W-1:0]`, `len = data_in[DATA_W-1:ADDR_W]`.
  - Then `len` payload bytes (0 allowed).
  - Then the parity byte, equal to the XOR of the header and all payload bytes.
- **Byte consumption.** A byte is consumed on an edge where `busy`=0 and the FSM is in IDLE (with `pkt_valid`=1), LOAD or DROP.
- **FSM states.**
  - IDLE: `busy`=0. On a consumed header, latch it into the hold register, init parity = header, payload count = 0.
    - `addr >= NUM_PORTS` -> DROP.
    - Target FIFO empty -> LFD.
    - Target FIFO not empty -> WAIT_EMPTY.
  - WAIT_EMPTY: `busy`=1. Go to LFD when the target FIFO is empty.
  - LFD: `busy`=1. Write the held header to the target FIFO, then go to LOAD.
  - LOAD: `busy` = target FIFO full.
    - Each consumed byte with `pkt_valid`=1 is written to the FIFO, XORed into parity, and increments the count.
    - The first consumed byte with `pkt_valid`=0 is the parity byte: write it, compare, go to CHECK.
  - CHECK: `busy`=1, one cycle. `err`=1 if the parity byte differs from the running parity or count != `len`. Then go to IDLE.
  - DROP: `busy`=0. Consume and discard bytes until a `pkt_valid`=0 byte is consumed; `drop`=1 for the next cycle; go to IDLE.
- **Output FIFOs.** Packets are stored verbatim: header, payload, parity.
  - Read: `read_enb[k]`=1 and non-empty at an edge -> `data_out[k]` loads the head entry on that edge. Otherwise `data_out[k]` holds its value.
  - `vld_out[k]` = FIFO k non-empty.
  - Read while empty: no effect.
- **Write/read boundaries.**
  - Full FIFO with a simultaneous read: the read completes, the write is blocked by `busy`, and `busy` falls the next cycle.
  - Empty FIFO with a simultaneous write and read: the write lands, the read is ignored.
- **Soft-reset timeout.** A per-port counter increments while `vld_out[k]`=1 and `read_enb[k]`=0. It clears on a read or when the FIFO is empty.
  - At `TIMEOUT` consecutive stalled cycles, FIFO k is flushed on that edge.
  - If the FSM is in WAIT_EMPTY, LFD or LOAD for port k, the FSM goes to DROP: the rest of the packet is discarded and `drop` pulses at its end.

## Timing
- **Reset** (`resetn`=0 at an edge): FSM to IDLE; all FIFOs emptied; timeout counters cleared.
  - Output values after reset: `data_out`=0, `vld_out`=0, `busy`=0, `err`=0, `drop`=0.
  - Reset mid-packet discards that packet; upstream restarts from a header.
- **Header latency.** Header consumed at edge t; LFD writes it at edge t+1; `vld_out` is high after edge t+1.
- **Payload and parity.** Payload byte consumed at edge t is in the FIFO after edge t. Parity consumed at t; CHECK occupies cycle t..t+1, with `err` high during it.
- **Read latency:** one edge.
- **Minimum packet cost:** `len`+4 cycles (header, LFD, `len` payload, parity, CHECK).
- **Back-to-back packets:** the next header is accepted in IDLE the cycle after CHECK.

## Test plan
- **Nominal packet.** Header 0x0D (port 1, `len` 3), payload 0x11 0x22 0x33, parity 0x0D, `read_enb[1]` held high -> `data_out[1]` shows 0x0D, 0x11, 0x22, 0x33, 0x0D; `err`=0; `vld_out[1]` falls after the last read.
- **Parity error.** Same packet with parity 0x00 -> `err` one-cycle pulse in CHECK; all 5 bytes still stored. Separately, `len`=3 with 2 payload bytes -> `err` pulse.
- **Bad address.** Header 0x0B (addr 3, `NUM_PORTS`=3) plus 2 bytes plus parity -> `busy` stays 0, `drop` pulses after the parity byte, all `vld_out`=0.
- **Full FIFO.** Header 0x50 (port 0, `len` 20), no reads -> `busy` rises once 16 entries are stored. One read -> `busy` falls the next cycle, and the remaining bytes complete with `err`=0.
- **Timeout.** Port 2 holds a packet with no reads for 30 cycles -> `vld_out[2]` falls after the 30th edge. Repeating this while port 2 is loading -> `drop` pulses at packet end.
- **Second packet to an occupied port.** Send a second packet to port 0 while port 0 is non-empty -> `busy`=1 in WAIT_EMPTY until the reader drains port 0; then the header is written and the packet completes. Rerun the suite with `NUM_PORTS`=4, `DATA_W`=16, `FIFO_DEPTH`=8.
